// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encodings,
// memory access size and access-class helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [2:0] MEM_SIZE_WORD = 3'd2;

  // Word class: LW/SW plus every unused encoding, which all have funct3[1] set.
  function automatic logic is_word(input logic [2:0] funct3);
    return funct3[1];
  endfunction

  // Half class: LH/LHU/SH (funct3[1:0] == 1).
  function automatic logic is_half(input logic [2:0] funct3);
    return funct3[1:0] == 2'd1;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return (is_word(funct3) && addr_lo != 2'd0) || (is_half(funct3) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Bundle of the LSU request/response handshake and the word-wide memory port.
// slave: the LSU itself. master: the pipeline stage and memory responder.
interface lsu_mem_access_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [4:0]       req_rd_sel;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic [4:0]       resp_rd_sel;
  logic             o_misalign;

  logic             mem_rd_en;
  logic [2:0]       mem_rd_size;
  logic [WIDTH-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic             mem_wr_en;
  logic [2:0]       mem_wr_size;
  logic [WIDTH-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd_sel, mem_rd_data,
    output req_ready, resp_valid, resp_data, resp_rd_sel, o_misalign,
           mem_rd_en, mem_rd_size, mem_rd_addr, mem_wr_en, mem_wr_size, mem_wr_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd_sel, mem_rd_data,
    input  req_ready, resp_valid, resp_data, resp_rd_sel, o_misalign,
           mem_rd_en, mem_rd_size, mem_rd_addr, mem_wr_en, mem_wr_size, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_align.sv
// Lane logic: little-endian extract + sign/zero extend for loads, and
// byte/half merge of store data into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [15:0]      wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] merge_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        ext_bit;

  // Select the addressed lane and extend it; word class passes through.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    byte_lane = rd_data[8*addr_lo +: 8];
    half_lane = rd_data[16*addr_lo[1] +: 16];
    ext_bit   = 1'b0;
    load_data = rd_data;
    if (is_half(funct3)) begin
      ext_bit   = ~funct3[2] & half_lane[15];
      load_data = {{(WIDTH-16){ext_bit}}, half_lane};
    end else if (!is_word(funct3)) begin
      ext_bit   = ~funct3[2] & byte_lane[7];
      load_data = {{(WIDTH-8){ext_bit}}, byte_lane};
    end
  end

  // Overlay the store lane onto the fetched word for SB/SH.
  always_comb begin
    merge_word = rd_data;
    if (is_half(funct3))
      merge_word[16*addr_lo[1] +: 16] = wdata;
    else if (!is_word(funct3))
      merge_word[8*addr_lo +: 8] = wdata[7:0];
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store initiator between the MEM stage and a word-indexed data memory.
// One request at a time; SB/SH done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  input logic               halt,
  lsu_mem_access_if.slave   bus
);

  logic [1:0]       state;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [15:0]      wdata_q;
  logic [4:0]       rd_sel_q;
  logic [WIDTH-1:0] wr_word_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [4:0]       resp_rd_sel_q;
  logic             misalign_q;

  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merge_word;
  logic             misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rd_data    (bus.mem_rd_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // FSM and request/response registers; halt freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state         <= S_IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_sel_q      <= '0;
      wr_word_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_rd_sel_q <= '0;
      misalign_q    <= 1'b0;
    end else if (!halt) begin
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata[15:0];
            rd_sel_q <= bus.req_rd_sel;
            if (misaligned) begin
              misalign_q <= 1'b1;
            end else if (bus.req_we && is_word(bus.req_funct3)) begin
              wr_word_q <= bus.req_wdata;
              state     <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          if (we_q) begin
            wr_word_q <= merge_word;
            state     <= S_WR;
          end else begin
            resp_valid_q  <= 1'b1;
            resp_data_q   <= load_data;
            resp_rd_sel_q <= rd_sel_q;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is also masked while reset is asserted so the port reads idle-zero then.
  assign bus.req_ready   = reset && (state == S_IDLE) && !halt;

  assign bus.mem_rd_en   = (state == S_RD) && !halt;
  assign bus.mem_rd_size = MEM_SIZE_WORD;
  assign bus.mem_rd_addr = (state == S_RD) ? (addr_q >> 2) : '0;
  assign bus.mem_wr_en   = (state == S_WR) && !halt;
  assign bus.mem_wr_size = MEM_SIZE_WORD;
  assign bus.mem_wr_addr = (state == S_WR) ? (addr_q >> 2) : '0;
  assign bus.mem_wr_data = (state == S_WR) ? wr_word_q : '0;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_rd_sel = resp_rd_sel_q;
  assign bus.o_misalign  = misalign_q;

endmodule
